ofmap_assembler: RTL and testbench
==================================

// Module: ofmap_assembler
// PURPOSE
//  Write-back end of the convolution datapath. Accepts half-row result vectors from the PE array
//  and assembles them into the flat output feature map, one (row, column-half) slot per transfer.
//  Drives rowNumber/column back to the receptive-field selector so both ends step in lockstep.
//  Raises done once all OUT_H x 2 slots are written; featureMap is then consumed downstream.
// PARAMETERS
//  DATA_WIDTH  32  bits per result word
//  H           32  input image height
//  W           32  input image width
//  F           5   filter size; OUT_H=H-F+1=28, OUT_W=W-F+1=28, HALF=OUT_W/2=14 (OUT_W must be even)
// PORTS
//  clk         in   1                        single clock, all logic rising-edge
//  reset_n     in   1                        synchronous, active-low reset
//  start       in   1                        pulse: begin or restart a frame
//  in_valid    in   1                        PE-array result vector valid
//  in_ready    out  1                        assembler can accept a vector
//  in_data     in   [0:HALF*DATA_WIDTH-1]    HALF results; word j at [j*DATA_WIDTH+:DATA_WIDTH]
//  rowNumber   out  [5:0]                    output row of the next expected vector
//  column      out  [5:0]                    0 = left half (cols 0..HALF-1), 1 = right half
//  featureMap  out  [0:OUT_H*OUT_W*DATA_WIDTH-1]  element (r,c) at [(r*OUT_W+c)*DATA_WIDTH+:DATA_WIDTH]
//  done        out  1                        level: frame complete, featureMap stable
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state=IDLE, rowNumber=0, column=0, done=0, in_ready=0, featureMap=0.
//  - States: IDLE, COLLECT, DONE. in_ready = (state==COLLECT), decoded from registered state only.
//  - IDLE: start=1 -> COLLECT; rowNumber=0, column=0, featureMap cleared to 0 on same edge.
//  - COLLECT: transfer when in_valid && in_ready at rising edge. Transfer writes word j of in_data
//    to element (rowNumber, column*HALF+j), j=0..HALF-1; visible on featureMap the next cycle.
//  - Counter advance per transfer: column 0->1; column 1->0 with rowNumber+1.
//  - Last transfer (rowNumber=OUT_H-1, column=1): -> DONE, done=1 from next cycle, rowNumber/column
//    return to 0, in_ready drops next cycle; no further writes accepted.
//  - in_valid=0 in COLLECT: hold all state; in_valid while not in COLLECT: ignored, no write.
//  - DONE: done held high, featureMap frozen, until start=1 -> COLLECT with clear as in IDLE
//    (done=0 the next cycle).
//  - start=1 in COLLECT: abort and restart: counters to 0, featureMap cleared; a same-cycle
//    transfer is discarded (start has priority).
//  - reset_n=0 mid-frame: overrides everything, full reset values next cycle.
//  - No arithmetic on data: words copied bit-exact, no truncation or sign handling.
//  - Throughput: one vector per cycle when in_valid held; frame = 2*OUT_H = 56 transfers min.
// STRUCTURE
//  - Shared package cnn_pkg: DATA_WIDTH default, OUT_H/OUT_W/HALF derivation as localparams,
//    state encoding IDLE=2'd0, COLLECT=2'd1, DONE=2'd2.
//  - One sub-module: ofmap_slot_ctr (rowNumber/column counter with clear, advance, last flag).
//  - Top holds FSM and featureMap register array with per-slot write enable decoded from counter.
// TESTING
//  - Reset: hold reset_n=0 2 cycles with in_valid=1 -> done=0, in_ready=0, featureMap all 0.
//  - Full frame: start, then 56 back-to-back vectors, word j of transfer t = t*16+j ->
//    element (t/2, (t%2)*14+j) = t*16+j; done=1 exactly one cycle after 56th transfer.
//  - Bubbles: same frame with in_valid random 50% -> identical featureMap, rowNumber/column stall.
//  - Late data: in_valid=1 in IDLE and DONE with 0xDEADBEEF -> featureMap unchanged, no count.
//  - Abort: start at transfer 20 with in_valid=1 -> that vector dropped, counters 0, map cleared,
//    then full 56-transfer frame completes normally.
//  - Mid-frame reset: reset_n=0 after transfer 30 -> IDLE, featureMap 0, start needed to resume.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared convolution-datapath constants and write-back FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int c_data_width = 32;
    localparam int c_h          = 32;
    localparam int c_w          = 32;
    localparam int c_f          = 5;
    localparam int c_out_h      = c_h - c_f + 1;
    localparam int c_out_w      = c_w - c_f + 1;
    localparam int c_half       = c_out_w / 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ofmap_slot_ctr.sv
`default_nettype none
// ============================================================================
// Module      : ofmap_slot_ctr
// Description : (row, column-half) slot counter for the output feature map.
// Revision    : 1.0 - initial release
// ============================================================================
module ofmap_slot_ctr
    import cnn_pkg::*;
#(
    parameter int OUT_H = c_out_h
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clr,
    input  logic       i_adv,
    output logic [5:0] o_row,
    output logic [5:0] o_col,
    output logic       o_last
);

    logic [5:0] r_row;
    logic [5:0] r_col;
    logic       w_last;

    assign w_last = (r_row == 6'(OUT_H - 1)) && (r_col == 6'd1);

    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
            if (r_col == 6'd1) begin
                r_col <= '0;
                // The final slot wraps so both ends are aligned for the next frame.
                r_row <= w_last ? 6'd0 : r_row + 6'd1;
            end else begin
                r_col <= 6'd1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_last;

endmodule
`default_nettype wire

// File: rtl/ofmap_assembler.sv
`default_nettype none
// ============================================================================
// Module      : ofmap_assembler
// Description : Assembles half-row PE result vectors into the flat output map.
// Revision    : 1.0 - initial release
// ============================================================================
module ofmap_assembler
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int H          = c_h,
    parameter int W          = c_w,
    parameter int F          = c_f
) (
    input  logic                                             clk,
    input  logic                                             reset_n,
    input  logic                                             start,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [0:((W-F+1)/2)*DATA_WIDTH-1]                in_data,
    output logic [5:0]                                       rowNumber,
    output logic [5:0]                                       column,
    output logic [0:(H-F+1)*(W-F+1)*DATA_WIDTH-1]            featureMap,
    output logic                                             done
);

    localparam int c_rows   = H - F + 1;
    localparam int c_cols   = W - F + 1;
    localparam int c_half_w = c_cols / 2;

    state_t r_state;
    logic   r_done;
    logic   w_ready;
    logic   w_xfer;
    logic   w_last;

    assign w_ready = (r_state == COLLECT);
    // start wins over a same-cycle transfer so an aborted vector never lands.
    assign w_xfer  = w_ready && in_valid && !start;

    ofmap_slot_ctr #(
        .OUT_H (c_rows)
    ) u_slot_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (start),
        .i_adv   (w_xfer),
        .o_row   (rowNumber),
        .o_col   (column),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) r_state <= COLLECT;
                end
                COLLECT: begin
                    if (!start && w_xfer && w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        r_state <= COLLECT;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = w_ready;
    assign done     = r_done;

    for (genvar gr = 0; gr < c_rows; gr++) begin : g_row
        for (genvar gc = 0; gc < c_cols; gc++) begin : g_col
            logic [DATA_WIDTH-1:0] r_slot;
            logic                  w_we;

            assign w_we = w_xfer && (rowNumber == 6'(gr)) && (column == 6'(gc / c_half_w));

            always_ff @(posedge clk) begin
                if (!reset_n || start) begin
                    r_slot <= '0;
                end else if (w_we) begin
                    r_slot <= in_data[(gc % c_half_w)*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            assign featureMap[(gr*c_cols + gc)*DATA_WIDTH +: DATA_WIDTH] = r_slot;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ofmap_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofmap_assembler
// Description : Randomized self-checking bench for ofmap_assembler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofmap_assembler;
    import cnn_pkg::*;

    localparam int c_dw    = c_data_width;
    localparam int c_oh    = c_out_h;
    localparam int c_ow    = c_out_w;
    localparam int c_hf    = c_half;
    localparam int c_nslot = c_oh * c_ow;
    localparam int c_nxfer = 2 * c_oh;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     start = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [0:c_hf*c_dw-1]     in_data = '0;
    logic [5:0]               rowNumber;
    logic [5:0]               column;
    logic [0:c_nslot*c_dw-1]  featureMap;
    logic                     done;

    ofmap_assembler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .rowNumber  (rowNumber),
        .column     (column),
        .featureMap (featureMap),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: map contents, frame phase (0 idle, 1 collecting, 2 done), transfers this frame.
    logic [c_dw-1:0] exp_map [c_nslot];
    int              m_phase = 0;
    int              m_t     = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int e = 0; e < c_nslot; e++) exp_map[e] = '0;
        m_t = 0;
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            model_clear();
            m_phase = 0;
        end else if (start) begin
            model_clear();
            m_phase = 1;
        end else if (m_phase == 1 && in_valid) begin
            for (int j = 0; j < c_hf; j++)
                exp_map[(m_t / 2) * c_ow + (m_t % 2) * c_hf + j] = in_data[j*c_dw +: c_dw];
            m_t++;
            if (m_t == c_nxfer) begin
                m_phase = 2;
                m_t     = 0;
            end
        end
    endtask

    task automatic check_ports();
        check_val("rowNumber", 32'(rowNumber), 32'(m_t / 2));
        check_val("column",    32'(column),    32'(m_t % 2));
        check_val("in_ready",  32'(in_ready),  32'(m_phase == 1));
        check_val("done",      32'(done),      32'(m_phase == 2));
    endtask

    task automatic step(input bit s, input bit v, input bit rn);
        reset_n  = rn;
        start    = s;
        in_valid = v;
        @(posedge clk);
        model_edge();
        #1;
        check_ports();
    endtask

    task automatic load_vec(input int t, input bit rnd);
        for (int j = 0; j < c_hf; j++)
            in_data[j*c_dw +: c_dw] = rnd ? c_dw'($urandom) : c_dw'(t * 16 + j);
    endtask

    task automatic load_dead();
        for (int j = 0; j < c_hf; j++) in_data[j*c_dw +: c_dw] = 32'hDEADBEEF;
    endtask

    task automatic check_map(input string tag);
        for (int e = 0; e < c_nslot; e++)
            check_val($sformatf("%s[%0d]", tag, e), featureMap[e*c_dw +: c_dw], exp_map[e]);
    endtask

    task automatic run_frame(input bit bubbles, input bit rnd);
        int n = 0;
        while (m_phase == 1 && n < 2000) begin
            load_vec(m_t, rnd);
            step(1'b0, bubbles ? 1'($urandom_range(1, 0)) : 1'b1, 1'b1);
            n++;
        end
        check_val("frame_complete", 32'(m_phase == 2), 32'd1);
    endtask

    initial begin
        load_vec(0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_map("reset_map");

        load_dead();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_map("idle_late");

        step(1'b1, 1'b0, 1'b1);
        run_frame(1'b0, 1'b0);
        check_map("full_frame");

        load_dead();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        check_map("done_late");

        step(1'b1, 1'b0, 1'b1);
        run_frame(1'b1, 1'b0);
        check_map("bubbles");

        step(1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 20; t++) begin
            load_vec(t, 1'b0);
            step(1'b0, 1'b1, 1'b1);
        end
        load_vec(20, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_map("abort_clear");
        run_frame(1'b0, 1'b1);
        check_map("after_abort");

        step(1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 30; t++) begin
            load_vec(t, 1'b1);
            step(1'b0, 1'b1, 1'b1);
        end
        step(1'b0, 1'b1, 1'b0);
        check_map("mid_reset");
        load_dead();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_map("post_reset_idle");
        step(1'b1, 1'b0, 1'b1);
        run_frame(1'b1, 1'b1);
        check_map("resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
